// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: result classes,
// initial result-ready countdowns and the zero register.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_NONE = 2'd3
    } cls_e;

    localparam int RDY_ALU  = 0;
    localparam int RDY_LOAD = 1;
    localparam int REG_ZERO = 0;

    function automatic int init_rdy(input cls_e cls, input int mul_lat);
        int r;
        r = RDY_ALU;
        unique case (cls)
            CLS_ALU:  r = RDY_ALU;
            CLS_LOAD: r = RDY_LOAD;
            CLS_MUL:  r = mul_lat - 1;
            CLS_NONE: r = 0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sb_src_lookup.sv
// Youngest-match priority encoder for one decode source:
// reports a hazard if the youngest producer is unready, else its select.
module sb_src_lookup
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int FW    = 3
) (
    input  logic                      used,
    input  logic [AW-1:0]             addr,
    input  logic [DEPTH-1:0]          ent_valid,
    input  logic [DEPTH-1:0]          ent_we,
    input  logic [DEPTH-1:0][AW-1:0]  ent_addr,
    input  logic [DEPTH-1:0]          ent_busy,
    output logic                      hazard,
    output logic [FW-1:0]             sel
);

    logic          found;
    logic          found_busy;
    logic [FW-1:0] found_sel;

    // Scan oldest to youngest so the lowest index wins.
    always_comb begin
        found      = 1'b0;
        found_busy = 1'b0;
        found_sel  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_valid[i] && ent_we[i] && ent_addr[i] == addr) begin
                found      = 1'b1;
                found_busy = ent_busy[i];
                found_sel  = FW'(i + 1);
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        sel    = '0;
        if (used && addr != AW'(REG_ZERO) && found) begin
            if (found_busy) hazard = 1'b1;
            else            sel    = found_sel;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order hazard scoreboard beside decode: tracks in-flight destinations,
// produces decode stall, per-source forwarding selects and multiplier busy.
module hazard_scoreboard
    import mips_pipe_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int AW      = 5,
    parameter int MUL_LAT = 3,
    parameter int FW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          freeze,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic          id_rs_used,
    input  logic          id_rt_used,
    input  logic          id_dst_we,
    input  logic [AW-1:0] id_dst_addr,
    input  logic [1:0]    id_class,
    output logic          stall,
    output logic [FW-1:0] fwd_rs_sel,
    output logic [FW-1:0] fwd_rt_sel,
    output logic          mul_busy
);

    localparam int RW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    logic [DEPTH-1:0]          ent_valid;
    logic [DEPTH-1:0]          ent_we;
    logic [DEPTH-1:0][AW-1:0]  ent_addr;
    logic [DEPTH-1:0][RW-1:0]  ent_rdy;
    logic [DEPTH-1:0]          ent_busy;
    logic [RW-1:0]             mul_cnt;

    cls_e          cls;
    logic          is_mul;
    logic          dst_we;
    logic          haz_rs;
    logic          haz_rt;
    logic          haz_struct;
    logic          issue;
    logic [RW-1:0] rdy_init;

    assign cls        = cls_e'(id_class);
    assign is_mul     = (cls == CLS_MUL);
    assign dst_we     = id_dst_we && (cls != CLS_NONE);
    assign rdy_init   = RW'(init_rdy(cls, MUL_LAT));
    assign haz_struct = id_valid && is_mul && (mul_cnt != '0);
    assign stall      = id_valid && (haz_rs || haz_rt || haz_struct);
    assign issue      = id_valid && !stall && !freeze;
    assign mul_busy   = (mul_cnt != '0);

    always_comb begin
        ent_busy = '0;
        for (int i = 0; i < DEPTH; i++) ent_busy[i] = (ent_rdy[i] != '0);
    end

    sb_src_lookup #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_rs (
        .used      (id_rs_used),
        .addr      (id_rs_addr),
        .ent_valid (ent_valid),
        .ent_we    (ent_we),
        .ent_addr  (ent_addr),
        .ent_busy  (ent_busy),
        .hazard    (haz_rs),
        .sel       (fwd_rs_sel)
    );

    sb_src_lookup #(.DEPTH(DEPTH), .AW(AW), .FW(FW)) u_rt (
        .used      (id_rt_used),
        .addr      (id_rt_addr),
        .ent_valid (ent_valid),
        .ent_we    (ent_we),
        .ent_addr  (ent_addr),
        .ent_busy  (ent_busy),
        .hazard    (haz_rt),
        .sel       (fwd_rt_sel)
    );

    // The last entry falls off: the register file is write-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_we    <= '0;
            ent_addr  <= '0;
            ent_rdy   <= '0;
        end else if (!freeze) begin
            for (int i = 1; i < DEPTH; i++) begin
                ent_valid[i] <= ent_valid[i-1];
                ent_we[i]    <= ent_we[i-1];
                ent_addr[i]  <= ent_addr[i-1];
                ent_rdy[i]   <= (ent_rdy[i-1] != '0) ?
                                ent_rdy[i-1] - RW'(1) : '0;
            end
            ent_valid[0] <= issue;
            ent_we[0]    <= issue && dst_we;
            ent_addr[0]  <= id_dst_addr;
            ent_rdy[0]   <= issue ? rdy_init : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= '0;
        end else if (issue && is_mul) begin
            mul_cnt <= RW'(MUL_LAT - 1);
        end else if (!freeze && mul_cnt != '0) begin
            mul_cnt <= mul_cnt - RW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: each cycle's expected outputs are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_hazard_scoreboard;

    localparam int DEPTH   = 4;
    localparam int AW      = 5;
    localparam int MUL_LAT = 3;
    localparam int FW      = 3;

    localparam logic [1:0] C_ALU  = 2'd0;
    localparam logic [1:0] C_LOAD = 2'd1;
    localparam logic [1:0] C_MUL  = 2'd2;
    localparam logic [1:0] C_NONE = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          freeze;
    logic          id_valid;
    logic [AW-1:0] id_rs_addr;
    logic [AW-1:0] id_rt_addr;
    logic          id_rs_used;
    logic          id_rt_used;
    logic          id_dst_we;
    logic [AW-1:0] id_dst_addr;
    logic [1:0]    id_class;
    logic          stall;
    logic [FW-1:0] fwd_rs_sel;
    logic [FW-1:0] fwd_rt_sel;
    logic          mul_busy;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic       rsu;
        logic [4:0] rt;
        logic       rtu;
        logic       we;
        logic [4:0] dst;
        logic [1:0] cls;
        logic       frz;
    } stim_t;

    typedef struct packed {
        logic       stall;
        logic [2:0] rs_sel;
        logic [2:0] rt_sel;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .DEPTH(DEPTH), .AW(AW), .MUL_LAT(MUL_LAT), .FW(FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freeze      (freeze),
        .id_valid    (id_valid),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_dst_we   (id_dst_we),
        .id_dst_addr (id_dst_addr),
        .id_class    (id_class),
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .mul_busy    (mul_busy)
    );

    function automatic stim_t wr(input logic [1:0] c, input logic [4:0] d);
        return '{v:1'b1, rs:5'd0, rsu:1'b0, rt:5'd0, rtu:1'b0,
                 we:1'b1, dst:d, cls:c, frz:1'b0};
    endfunction

    function automatic stim_t rd(input logic [4:0] rs, input logic rsu,
                                 input logic [4:0] rt, input logic rtu,
                                 input logic frz);
        return '{v:1'b1, rs:rs, rsu:rsu, rt:rt, rtu:rtu,
                 we:1'b0, dst:5'd0, cls:C_NONE, frz:frz};
    endfunction

    function automatic stim_t idle();
        return '{v:1'b0, rs:5'd0, rsu:1'b0, rt:5'd0, rtu:1'b0,
                 we:1'b0, dst:5'd0, cls:C_NONE, frz:1'b0};
    endfunction

    function automatic exp_t ex(input logic s, input logic [2:0] a,
                                input logic [2:0] b, input logic m);
        return '{stall:s, rs_sel:a, rt_sel:b, busy:m};
    endfunction

    function automatic exp_t observe();
        return '{stall:stall, rs_sel:fwd_rs_sel,
                 rt_sel:fwd_rt_sel, busy:mul_busy};
    endfunction

    task automatic drive(input stim_t s);
        id_valid    = s.v;
        id_rs_addr  = s.rs;
        id_rs_used  = s.rsu;
        id_rt_addr  = s.rt;
        id_rt_used  = s.rtu;
        id_dst_we   = s.we;
        id_dst_addr = s.dst;
        id_class    = s.cls;
        freeze      = s.frz;
    endtask

    task automatic flush();
        for (int i = 0; i < DEPTH + MUL_LAT; i++) begin
            @(negedge clk);
            drive(idle());
        end
    endtask

    task automatic test_reset();
        exp_t got, want;
        rst_n = 1'b0;
        drive(rd(5'd5, 1'b1, 5'd6, 1'b1, 1'b0));
        exp_q.push_back(ex(1'b0, 3'd0, 3'd0, 1'b0));
        #2;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset: got %b required %b", got, want);
        end
        @(negedge clk);
        @(negedge clk);
        drive(idle());
        rst_n = 1'b1;
    endtask

    task automatic test_alu_fwd();
        stim_t s[6];
        exp_t  e[6];
        exp_t  got, want;
        s = '{wr(C_ALU, 5'd5), rd(5'd5, 1, 5'd0, 0, 0),
              rd(5'd5, 1, 5'd0, 0, 0), rd(5'd0, 0, 5'd5, 1, 0),
              rd(5'd0, 0, 5'd5, 1, 0), rd(5'd5, 1, 5'd5, 1, 0)};
        e = '{ex(0, 0, 0, 0), ex(0, 1, 0, 0), ex(0, 2, 0, 0),
              ex(0, 0, 3, 0), ex(0, 0, 4, 0), ex(0, 0, 0, 0)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL alu_fwd[%0d]: got %b required %b", i, got, want);
            end
        end
        flush();
    endtask

    task automatic test_load_use();
        stim_t s[3];
        exp_t  e[3];
        exp_t  got, want;
        s = '{wr(C_LOAD, 5'd8), rd(5'd0, 0, 5'd8, 1, 0),
              rd(5'd0, 0, 5'd8, 1, 0)};
        e = '{ex(0, 0, 0, 0), ex(1, 0, 0, 0), ex(0, 0, 2, 0)};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b required %b", i, got, want);
            end
        end
        flush();
    endtask

    task automatic test_mul();
        stim_t s[7];
        exp_t  e[7];
        stim_t m2;
        exp_t  got, want;
        m2 = wr(C_MUL, 5'd9);
        m2.rs  = 5'd3;
        m2.rsu = 1'b1;
        s = '{wr(C_MUL, 5'd3), m2, m2, m2,
              rd(5'd3, 1, 5'd0, 0, 0), idle(), idle()};
        e = '{ex(0, 0, 0, 0), ex(1, 0, 0, 1), ex(1, 0, 0, 1),
              ex(0, 3, 0, 0), ex(0, 4, 0, 1), ex(0, 0, 0, 1),
              ex(0, 0, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mul[%0d]: got %b required %b", i, got, want);
            end
        end
        flush();
    endtask

    task automatic test_waw();
        stim_t s[4];
        exp_t  e[4];
        exp_t  got, want;
        s = '{wr(C_ALU, 5'd4), wr(C_LOAD, 5'd4),
              rd(5'd4, 1, 5'd0, 0, 0), rd(5'd4, 1, 5'd0, 0, 0)};
        e = '{ex(0, 0, 0, 0), ex(0, 0, 0, 0), ex(1, 0, 0, 0),
              ex(0, 2, 0, 0)};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL waw[%0d]: got %b required %b", i, got, want);
            end
        end
        flush();
    endtask

    task automatic test_zero_unused();
        stim_t s[5];
        exp_t  e[5];
        exp_t  got, want;
        s = '{wr(C_LOAD, 5'd0), rd(5'd0, 1, 5'd0, 1, 0),
              wr(C_LOAD, 5'd7), rd(5'd7, 0, 5'd7, 0, 0),
              rd(5'd7, 1, 5'd0, 0, 0)};
        e = '{ex(0, 0, 0, 0), ex(0, 0, 0, 0), ex(0, 0, 0, 0),
              ex(0, 0, 0, 0), ex(0, 2, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL zero_unused[%0d]: got %b required %b", i, got, want);
            end
        end
        flush();
    endtask

    task automatic test_both_sources();
        stim_t s[5];
        exp_t  e[5];
        exp_t  got, want;
        s = '{wr(C_LOAD, 5'd11), wr(C_MUL, 5'd10),
              rd(5'd10, 1, 5'd11, 1, 0), rd(5'd10, 1, 5'd11, 1, 0),
              rd(5'd10, 1, 5'd11, 1, 0)};
        e = '{ex(0, 0, 0, 0), ex(0, 0, 0, 0), ex(1, 0, 2, 1),
              ex(1, 0, 3, 1), ex(0, 3, 4, 0)};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL both_src[%0d]: got %b required %b", i, got, want);
            end
        end
        flush();
    endtask

    task automatic test_freeze();
        stim_t s[6];
        exp_t  e[6];
        exp_t  got, want;
        s = '{wr(C_LOAD, 5'd8), rd(5'd0, 0, 5'd8, 1, 1),
              rd(5'd0, 0, 5'd8, 1, 1), rd(5'd0, 0, 5'd8, 1, 1),
              rd(5'd0, 0, 5'd8, 1, 0), rd(5'd0, 0, 5'd8, 1, 0)};
        e = '{ex(0, 0, 0, 0), ex(1, 0, 0, 0), ex(1, 0, 0, 0),
              ex(1, 0, 0, 0), ex(1, 0, 0, 0), ex(0, 0, 2, 0)};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(s[i]);
            exp_q.push_back(e[i]);
            #1;
            got  = observe();
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL freeze[%0d]: got %b required %b", i, got, want);
            end
        end
        flush();
    endtask

    task automatic test_reset_mid_mul();
        exp_t got, want;
        @(negedge clk);
        drive(wr(C_MUL, 5'd3));
        @(negedge clk);
        drive(rd(5'd3, 1, 5'd0, 0, 0));
        exp_q.push_back(ex(1, 0, 0, 1));
        #1;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL mid_mul_pre: got %b required %b", got, want);
        end
        rst_n = 1'b0;
        exp_q.push_back(ex(0, 0, 0, 0));
        #1;
        got  = observe();
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL mid_mul_reset: got %b required %b", got, want);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(idle());
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_mul();
        test_waw();
        test_zero_unused();
        test_both_sources();
        test_freeze();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised in-order hazard scoreboard for the MIPS pipeline, sitting beside decode. It tracks destination registers of in-flight instructions across DEPTH downstream stages with per-entry result-ready countdowns. From that state it produces the decode stall and per-source forwarding selects. It generalises the fixed EX/MEM single-load-use check to arbitrary depth, multi-cycle (MUL) producers and a non-pipelined multiplier structural hazard.

## Interface
Parameters:
- DEPTH, 4: tracked stages after decode; entry 0 = EX, entry DEPTH-1 = last stage before register-file write; must be ≥ MUL_LAT.
- AW, 5: register address width.
- MUL_LAT, 3: multiplier latency in cycles; ≥ 2.
- FW, $clog2(DEPTH+1): forwarding-select width.

Ports:
- clk  in  1  pipeline clock, rising edge; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- freeze  in  1  downstream stall; holds all state.
- id_valid  in  1  instruction present in decode.
- id_rs_addr, id_rt_addr  in  AW  source register addresses.
- id_rs_used, id_rt_used  in  1  source actually read.
- id_dst_we  in  1  instruction writes a register.
- id_dst_addr  in  AW  destination register.
- id_class  in  2  result class: 0 ALU, 1 LOAD, 2 MUL, 3 NONE (NONE treated as id_dst_we=0).
- stall  out  1  hold decode and insert a bubble.
- fwd_rs_sel, fwd_rt_sel  out  FW  0 = register file; k = forward from entry k-1.
- mul_busy  out  1  multiplier occupied.

## Operation
- Entry fields: valid, we, addr[AW], rdy (width $clog2(MUL_LAT)).
- Issue: issue = id_valid & ~stall & ~freeze.
- Initial rdy on issue: ALU 0, LOAD 1, MUL MUL_LAT-1.
- Advance (freeze=0):
  - entry i+1 ← entry i, with rdy decremented, saturating at 0.
  - entry 0 ← issued instruction if issue, else a bubble (valid=0).
  - Entry DEPTH-1 is discarded; the register file is write-first, so no forwarding is needed after it.
- Source lookup, per source with used=1 and addr≠0:
  - Find the lowest-index (youngest) entry with valid & we & addr match.
  - Match with rdy≠0 → data hazard.
  - Match with rdy=0 → select = index+1.
  - No match → select 0.
  - Unused source or addr=0 → select 0, never a hazard.
- Structural hazard: id_valid & class MUL & mul_cnt≠0.
- stall = id_valid & (data hazard on rs | data hazard on rt | structural hazard).
- mul_cnt:
  - Loads MUL_LAT-1 on a MUL issue.
  - Otherwise decrements when ~freeze and nonzero.
  - mul_busy = (mul_cnt≠0).

## Timing
- stall, fwd_*_sel and mul_busy are combinational from current state plus id_* inputs; there is no added latency.
- Reset (async, rst_n=0):
  - All entries valid=0, mul_cnt=0, taking effect immediately, including mid-MUL.
  - Consequently stall=0, fwd selects=0, mul_busy=0.
- Producer issued at cycle t (no freeze) is forwardable from cycle t+1+initial rdy:
  - ALU: select 1 at t+1.
  - LOAD: stall at t+1, select 2 at t+2.
  - MUL: stall at t+1..t+MUL_LAT-1, select MUL_LAT at t+MUL_LAT.
- Back-to-back MULs issue no closer than MUL_LAT cycles apart.
- WAW: the youngest producer governs. Stall if it is unready even when an older match is ready.
- freeze=1:
  - No shift, no rdy or mul_cnt decrement, no issue.
  - Outputs remain consistent with the held state.
  - freeze takes priority over stall.
- Both sources hazarded → one stall. It clears only when both sources resolve.

## Structure
- Shared package mips_pipe_pkg:
  - class encodings CLS_ALU, CLS_LOAD, CLS_MUL, CLS_NONE;
  - rdy initial values;
  - REG_ZERO constant.
- Sub-module sb_src_lookup: the youngest-match priority encoder over DEPTH entries, returning hazard and select. Instantiated twice (rs, rt).
- Top level holds the entry shift register, mul_cnt and stall combine.

## Test plan
- ALU r5 at t; at t+1 rs=r5 used → stall=0, fwd_rs_sel=1; at t+2 same read → fwd_rs_sel=2.
- LOAD r8 at t; at t+1 rt=r8 used → stall=1 for one cycle; at t+2 fwd_rt_sel=2, stall=0.
- MUL r3 at t (MUL_LAT=3); rs=r3 → stall at t+1,t+2, fwd_rs_sel=3 at t+3. A second MUL at t+1 → stall until t+3; mul_busy=1 over t+1..t+2.
- ALU r4 at t, LOAD r4 at t+1; read r4 at t+2 → stall=1; at t+3 fwd=2 (not 3).
- LOAD r0 then read r0; also id_rs_used=0 on matching addr → stall=0, select 0.
- freeze=1 for 3 cycles during a load-use stall → all outputs constant, stall resolves one advancing cycle after release. rst_n=0 mid-MUL → stall=0, mul_busy=0 without a clock edge.
